// File: rtl/sbox_scheduler.sv
// sbox_scheduler: time-multiplexes one shared 32-bit S-box column (four byte
// S-boxes) between the AES round datapath and key expansion.
//   A 128-bit SubBytes request is run through the column one 32-bit word per
//   cycle. A 32-bit SubWord request takes a single column cycle.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   st_req/st_in      state SubBytes request and 128-bit state (byte 0 = [0:7])
//   st_out/st_done    substituted state and its one-cycle valid pulse
//   kw_req/kw_in      key-expansion SubWord request and 32-bit word
//   kw_out/kw_done    substituted word and its one-cycle valid pulse
//   sb_in/sb_out      shared column input (0 when idle) and its combinational result
//   busy              high whenever the scheduler is not in IDLE
//
// Configuration
//   SBOX_SCHED_FAIR_EN  defined:   alternating priority on simultaneous requests
//                       undefined: key expansion always wins a simultaneous request
module sbox_scheduler (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           st_req,
    input  logic [0:127]   st_in,
    output logic [0:127]   st_out,
    output logic           st_done,
    input  logic           kw_req,
    input  logic [0:31]    kw_in,
    output logic [0:31]    kw_out,
    output logic           kw_done,
    output logic [0:31]    sb_in,
    input  logic [0:31]    sb_out,
    output logic           busy
);

    localparam int unsigned STATE_W = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned COL_W   = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ST   = 2'd1,
        S_KW   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [COL_W-1:0]     col_q, col_d;
    logic [0:STATE_W-1]   st_buf_q, st_buf_d;
    logic [0:STATE_W-1]   st_out_q, st_out_d;
    logic [0:WORD_W-1]    kw_out_q, kw_out_d;
    logic [0:WORD_W-1]    sb_in_q, sb_in_d;
    logic                 st_done_q, st_done_d;
    logic                 kw_done_q, kw_done_d;
    logic                 busy_q, busy_d;
    logic                 grant_st, grant_kw;

`ifdef SBOX_SCHED_FAIR_EN
    localparam logic GRANT_ST = 1'b0;
    localparam logic GRANT_KW = 1'b1;
    logic last_grant_q, last_grant_d;
`endif

    // Arbitration between the two requesters (only acted on in IDLE)
    always_comb begin
        grant_st = 1'b0;
        grant_kw = 1'b0;
`ifdef SBOX_SCHED_FAIR_EN
        if (st_req && kw_req) begin
            if (last_grant_q == GRANT_ST) begin
                grant_kw = 1'b1;
            end else begin
                grant_st = 1'b1;
            end
        end else begin
            grant_st = st_req;
            grant_kw = kw_req;
        end
`else
        grant_kw = kw_req;
        grant_st = st_req && !kw_req;
`endif
    end

    // Next-state and output logic. sb_in is registered one cycle ahead so the
    // column sees the right word throughout each ST/KW cycle; it also serves
    // as the key-word buffer since KW lasts a single cycle.
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        st_buf_d  = st_buf_q;
        st_out_d  = st_out_q;
        kw_out_d  = kw_out_q;
        sb_in_d   = '0;
        st_done_d = 1'b0;
        kw_done_d = 1'b0;
`ifdef SBOX_SCHED_FAIR_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (grant_st) begin
                    state_d  = S_ST;
                    col_d    = '0;
                    st_buf_d = st_in;
                    sb_in_d  = st_in[0:WORD_W-1];
`ifdef SBOX_SCHED_FAIR_EN
                    last_grant_d = GRANT_ST;
`endif
                end else if (grant_kw) begin
                    state_d = S_KW;
                    sb_in_d = kw_in;
`ifdef SBOX_SCHED_FAIR_EN
                    last_grant_d = GRANT_KW;
`endif
                end
            end
            S_ST: begin
                st_out_d[WORD_W*col_q +: WORD_W] = sb_out;
                col_d = col_q + COL_W'(1);
                if (col_q == COL_W'(3)) begin
                    state_d   = S_DONE;
                    st_done_d = 1'b1;
                end else begin
                    sb_in_d = st_buf_q[WORD_W*col_d +: WORD_W];
                end
            end
            S_KW: begin
                kw_out_d  = sb_out;
                state_d   = S_DONE;
                kw_done_d = 1'b1;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_q     <= '0;
            st_buf_q  <= '0;
            st_out_q  <= '0;
            kw_out_q  <= '0;
            sb_in_q   <= '0;
            st_done_q <= 1'b0;
            kw_done_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            st_buf_q  <= st_buf_d;
            st_out_q  <= st_out_d;
            kw_out_q  <= kw_out_d;
            sb_in_q   <= sb_in_d;
            st_done_q <= st_done_d;
            kw_done_q <= kw_done_d;
            busy_q    <= busy_d;
        end
    end

`ifdef SBOX_SCHED_FAIR_EN
    // Last grant starts at ST so key expansion wins the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= GRANT_ST;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign st_out  = st_out_q;
    assign st_done = st_done_q;
    assign kw_out  = kw_out_q;
    assign kw_done = kw_done_q;
    assign sb_in   = sb_in_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_sbox_scheduler.sv
// Directed self-checking bench for sbox_scheduler. Provides an AES S-box
// column model on sb_in/sb_out; expected outputs are hand-computed constants.
module tb_sbox_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         st_req, kw_req;
    logic [0:127] st_in, st_out;
    logic [0:31]  kw_in, kw_out, sb_in, sb_out;
    logic         st_done, kw_done, busy;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [0:127] ST_A   = 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808;
    localparam logic [0:127] ST_A_S = 128'hd42711ae_e0bf98f1_b8b45de5_1e415230;
    localparam logic [0:127] ST_01  = {16{8'h01}};
    localparam logic [0:127] ST_01S = {16{8'h7c}};
    localparam logic [0:127] ST_0S  = {16{8'h63}};
    localparam logic [0:31]  KW_A   = 32'hcf4f3c09;
    localparam logic [0:31]  KW_A_S = 32'h8a84eb01;

    always #5 clk = ~clk;

    sbox_scheduler dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .st_req  (st_req),
        .st_in   (st_in),
        .st_out  (st_out),
        .st_done (st_done),
        .kw_req  (kw_req),
        .kw_in   (kw_in),
        .kw_out  (kw_out),
        .kw_done (kw_done),
        .sb_in   (sb_in),
        .sb_out  (sb_out),
        .busy    (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    // AES S-box: inverse (x^254) followed by the affine transform
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t, r, s;
        t = x; r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t = gmul(t, t);
            r = gmul(r, t);
        end
        s = r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
        return s;
    endfunction

    assign sb_out = {sbox(sb_in[0:7]), sbox(sb_in[8:15]), sbox(sb_in[16:23]), sbox(sb_in[24:31])};

    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1; st_req = 1'b0; kw_req = 1'b0; st_in = '0; kw_in = '0;
        #1 rst_n = 1'b0;
        #20;
        @(negedge clk);
        n_checks++; if (st_out !== 128'h0) begin n_fail++; $display("FAIL reset_st_out: got %h want 0", st_out); end
        n_checks++; if (kw_out !== 32'h0) begin n_fail++; $display("FAIL reset_kw_out: got %h want 0", kw_out); end
        n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL reset_st_done: got %b want 0", st_done); end
        n_checks++; if (kw_done !== 1'b0) begin n_fail++; $display("FAIL reset_kw_done: got %b want 0", kw_done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (sb_in !== 32'h0) begin n_fail++; $display("FAIL reset_sb_in: got %h want 0", sb_in); end
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_lone_state;
        st_in = ST_A; st_req = 1'b1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL st_busy_c0: got %b want 0", busy); end
        for (int cyc = 1; cyc <= 7; cyc++) begin
            next_cycle();
            n_checks++; if (st_done !== (cyc == 5)) begin n_fail++; $display("FAIL st_done_c%0d: got %b want %b", cyc, st_done, (cyc == 5)); end
            n_checks++; if (busy !== (cyc <= 5)) begin n_fail++; $display("FAIL st_busy_c%0d: got %b want %b", cyc, busy, (cyc <= 5)); end
            n_checks++; if (kw_done !== 1'b0) begin n_fail++; $display("FAIL st_kw_done_c%0d: got %b want 0", cyc, kw_done); end
            if (cyc == 1) begin
                n_checks++; if (sb_in !== 32'h193de3be) begin n_fail++; $display("FAIL st_sb_in_c1: got %h want 193de3be", sb_in); end
            end
            if (cyc == 2) begin
                n_checks++; if (sb_in !== 32'ha0f4e22b) begin n_fail++; $display("FAIL st_sb_in_c2: got %h want a0f4e22b", sb_in); end
            end
            if (cyc == 5) begin
                n_checks++; if (st_out !== ST_A_S) begin n_fail++; $display("FAIL st_out: got %h want %h", st_out, ST_A_S); end
                st_req = 1'b0;
            end
            if (cyc == 6) begin
                n_checks++; if (sb_in !== 32'h0) begin n_fail++; $display("FAIL st_sb_in_idle: got %h want 0", sb_in); end
            end
        end
    endtask

    task automatic test_lone_key;
        kw_in = KW_A; kw_req = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            next_cycle();
            n_checks++; if (kw_done !== (cyc == 2)) begin n_fail++; $display("FAIL kw_done_c%0d: got %b want %b", cyc, kw_done, (cyc == 2)); end
            n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL kw_st_done_c%0d: got %b want 0", cyc, st_done); end
            if (cyc == 1) begin
                n_checks++; if (sb_in !== KW_A) begin n_fail++; $display("FAIL kw_sb_in: got %h want %h", sb_in, KW_A); end
            end
            if (cyc == 2) begin
                n_checks++; if (kw_out !== KW_A_S) begin n_fail++; $display("FAIL kw_out: got %h want %h", kw_out, KW_A_S); end
                n_checks++; if (st_out !== ST_A_S) begin n_fail++; $display("FAIL kw_st_out_held: got %h want %h", st_out, ST_A_S); end
                kw_req = 1'b0;
            end
        end
    endtask

`ifndef SBOX_SCHED_FAIR_EN
    task automatic test_simultaneous;
        st_in = '0; kw_in = KW_A; st_req = 1'b1; kw_req = 1'b1;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            next_cycle();
            n_checks++; if (kw_done !== (cyc == 2)) begin n_fail++; $display("FAIL sim_kw_done_c%0d: got %b want %b", cyc, kw_done, (cyc == 2)); end
            n_checks++; if (st_done !== (cyc == 8)) begin n_fail++; $display("FAIL sim_st_done_c%0d: got %b want %b", cyc, st_done, (cyc == 8)); end
            if (cyc == 2) kw_req = 1'b0;
            if (cyc == 8) begin
                n_checks++; if (st_out !== ST_0S) begin n_fail++; $display("FAIL sim_st_out: got %h want %h", st_out, ST_0S); end
                st_req = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        st_in = ST_01; kw_in = KW_A; st_req = 1'b1; kw_req = 1'b1;
        for (int cyc = 1; cyc <= 15; cyc++) begin
            next_cycle();
            n_checks++; if (kw_done !== (cyc == 2 || cyc == 5 || cyc == 8)) begin n_fail++; $display("FAIL b2b_kw_done_c%0d: got %b", cyc, kw_done); end
            n_checks++; if (st_done !== (cyc == 14)) begin n_fail++; $display("FAIL b2b_st_done_c%0d: got %b want %b", cyc, st_done, (cyc == 14)); end
            if (cyc == 8) kw_req = 1'b0;
            if (cyc == 14) begin
                n_checks++; if (st_out !== ST_01S) begin n_fail++; $display("FAIL b2b_st_out: got %h want %h", st_out, ST_01S); end
                st_req = 1'b0;
            end
        end
    endtask
`else
    task automatic test_fair;
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        next_cycle();
        st_in = ST_01; kw_in = KW_A; st_req = 1'b1; kw_req = 1'b1;
        for (int cyc = 1; cyc <= 19; cyc++) begin
            next_cycle();
            n_checks++; if (kw_done !== (cyc == 2 || cyc == 11)) begin n_fail++; $display("FAIL fair_kw_done_c%0d: got %b", cyc, kw_done); end
            n_checks++; if (st_done !== (cyc == 8 || cyc == 17)) begin n_fail++; $display("FAIL fair_st_done_c%0d: got %b", cyc, st_done); end
            if (cyc == 8) begin
                n_checks++; if (st_out !== ST_01S) begin n_fail++; $display("FAIL fair_st_out: got %h want %h", st_out, ST_01S); end
            end
            if (cyc == 11) kw_req = 1'b0;
            if (cyc == 17) st_req = 1'b0;
        end
    endtask
`endif

    task automatic test_reset_mid;
        st_in = ST_A; st_req = 1'b1;
        next_cycle(); next_cycle(); next_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++; if (st_out !== 128'h0) begin n_fail++; $display("FAIL mid_st_out: got %h want 0", st_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b want 0", busy); end
        n_checks++; if (sb_in !== 32'h0) begin n_fail++; $display("FAIL mid_sb_in: got %h want 0", sb_in); end
        n_checks++; if (kw_out !== 32'h0) begin n_fail++; $display("FAIL mid_kw_out: got %h want 0", kw_out); end
        st_req = 1'b0;
        for (int cyc = 0; cyc < 3; cyc++) begin
            next_cycle();
            n_checks++; if (st_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done_c%0d: got %b want 0", cyc, st_done); end
        end
        rst_n = 1'b1;
        next_cycle();
        st_in = ST_A; st_req = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            next_cycle();
            n_checks++; if (st_done !== (cyc == 5)) begin n_fail++; $display("FAIL mid_fresh_done_c%0d: got %b want %b", cyc, st_done, (cyc == 5)); end
            if (cyc == 5) begin
                n_checks++; if (st_out !== ST_A_S) begin n_fail++; $display("FAIL mid_fresh_st_out: got %h want %h", st_out, ST_A_S); end
                st_req = 1'b0;
            end
        end
    endtask

    task automatic test_input_change;
        st_in = ST_01; st_req = 1'b1;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            next_cycle();
            if (cyc == 2) st_in = ST_A;
            n_checks++; if (st_done !== (cyc == 5)) begin n_fail++; $display("FAIL chg_done_c%0d: got %b want %b", cyc, st_done, (cyc == 5)); end
            if (cyc == 5) begin
                n_checks++; if (st_out !== ST_01S) begin n_fail++; $display("FAIL chg_st_out: got %h want %h", st_out, ST_01S); end
                st_req = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lone_state();
        test_lone_key();
`ifndef SBOX_SCHED_FAIR_EN
        test_simultaneous();
        test_back_to_back();
`else
        test_fair();
`endif
        test_reset_mid();
        test_input_change();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sbox_scheduler.md
# sbox_scheduler

Time-multiplexed scheduler for the shared 32-bit S-box column (four byte S-boxes) in the AES encryption core. It serves two requesters: the round datapath, which needs a full 128-bit SubBytes transform, and key expansion, which needs a 32-bit SubWord. A 128-bit state is sequenced through the column one word per cycle, and access between the two requesters is arbitrated. This replaces four duplicated S-box columns with one shared column.

## Interface
Parameters:
- none

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- st_req  input  1  round datapath requests a SubBytes transform; held until st_done
- st_in  input  [0:127]  state to substitute; byte 0 at bits [0:7]; stable while st_req is high
- st_out  output  [0:127]  substituted state; valid from st_done and held until the next state grant
- st_done  output  1  one-cycle pulse: st_out is valid
- kw_req  input  1  key expansion requests SubWord; held until kw_done
- kw_in  input  [0:31]  word to substitute
- kw_out  output  [0:31]  substituted word; held until the next key grant
- kw_done  output  1  one-cycle pulse: kw_out is valid
- sb_in  output  [0:31]  word driven to the shared S-box column; 0 when no column cycle is active
- sb_out  input  [0:31]  combinational S-box column result for sb_in
- busy  output  1  high in every state except IDLE

## Operation
- States: IDLE, ST, KW, DONE.
- **IDLE**
  - Samples st_req and kw_req.
  - On a grant, captures the granted input into an internal buffer.
  - State grant: go to ST with col=0. Key grant: go to KW.
- **ST**
  - sb_in = st_buf column col. Column c is bits [32c : 32c+31].
  - At each edge, sb_out is written into st_out column col, and col increments.
  - After col=3, go to DONE with owner=ST.
- **KW**
  - sb_in = kw_buf.
  - At the edge, sb_out is written into kw_out.
  - Go to DONE with owner=KW.
- **DONE**
  - Asserts the done pulse of the owner for exactly one cycle.
  - Requests are ignored in this state.
  - Always returns to IDLE.
- Arbitration, when both requests are high in IDLE: decided by the priority rule under Configuration.
- Requesters must deassert req on the edge after they see done. A req still high in the IDLE cycle after done is treated as a new request.
- A requester that deasserts req before its done does not abort the transaction. The transaction completes and done still pulses.
- st_in and kw_in are sampled only at grant. Later changes have no effect on the transaction in flight.
- st_out and kw_out are registers and retain their value between transactions. Columns of st_out not yet written during ST hold their previous value.

## Timing
- Reset values (asynchronous on rst_n low):
  - state=IDLE, col=0, last_grant=ST.
  - st_out=0, kw_out=0, st_done=0, kw_done=0, busy=0, sb_in=0.
- Reset mid-operation abandons the transaction. No done pulse is issued for it.
- State latency:
  - Request seen in IDLE at cycle 0.
  - ST occupies cycles 1–4.
  - st_done is high in cycle 5.
  - The earliest next grant is in cycle 6.
- Key latency:
  - Request seen at cycle 0.
  - KW in cycle 1.
  - kw_done is high in cycle 2.
- Throughput: one state transform per 6 cycles; one key word per 3 cycles.
- The S-box column is combinational. sb_out must settle within the same cycle as sb_in.

## Configuration
- Macro `SBOX_SCHED_FAIR_EN`.
- **Defined:** alternating priority.
  - When both requests are high in IDLE, the grant goes to the requester that was not last granted.
  - last_grant updates on every grant.
- **Undefined:** fixed priority. Key expansion always wins a simultaneous request. last_grant is not implemented.
- A lone request is granted immediately in both builds.

## Test plan
- **Lone state request**
  - Stimulus: st_in=193de3be_a0f4e22b_9ac68d2a_e9f84808.
  - Response: st_out=d42711ae_e0bf98f1_b8b45de5_1e415230, st_done high in exactly cycle 5, busy high in cycles 1–5.
- **Lone key request**
  - Stimulus: kw_in=cf4f3c09.
  - Response: kw_out=8a84eb01, kw_done in cycle 2, st_done stays 0.
- **Simultaneous requests, fixed build**
  - Stimulus: st_req and kw_req rise together.
  - Response: kw_done in cycle 2, st_done in cycle 8.
  - Repeat back to back: st_req is served only when kw_req is idle.
- **Simultaneous requests, SBOX_SCHED_FAIR_EN build**
  - Stimulus: both requests held continuously.
  - Response: grants alternate KW, ST, KW, ST (last_grant=ST from reset, so KW goes first). Done pulses in cycles 2, 8, 11, 17.
- **Reset mid-transform**
  - Stimulus: rst_n low during ST at col=2.
  - Response: all outputs 0 immediately, no st_done. After release, a fresh request completes correctly in 5 cycles.
- **Input change after grant**
  - Stimulus: change st_in in cycle 2.
  - Response: st_out still reflects the value sampled at grant.
